// File: rtl/lcd_de_receiver.sv
// DE-mode RGB565 sink: recovers pixel coordinates and line/frame boundaries from DE alone,
// and reports per-frame line count, checksum and geometry errors.
module lcd_de_receiver #(
    parameter int H_ACTIVE  = 480,
    parameter int V_ACTIVE  = 272,
    parameter int FRAME_GAP = 1000
) (
    input  logic        PixelClk,
    input  logic        RST,
    input  logic        LCD_DE,
    input  logic [4:0]  LCD_R,
    input  logic [5:0]  LCD_G,
    input  logic [4:0]  LCD_B,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_lines,
    output logic [15:0] frame_checksum,
    output logic        err_line_len,
    output logic        err_frame_height,
    output logic [15:0] frame_count
);

    localparam logic [15:0] H_L   = 16'(H_ACTIVE);
    localparam logic [15:0] V_L   = 16'(V_ACTIVE);
    localparam logic [15:0] GAP_L = 16'(FRAME_GAP);

    typedef enum logic [1:0] {S_SYNC, S_VBLANK, S_ACTIVE, S_HBLANK} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        r_de_p0;
    logic [15:0] r_rgb_p0;
    logic [15:0] r_gap;
    state_t      r_state;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_lines;
    logic [15:0] r_sum;
    logic        r_lerr;
    logic        r_end_p1;
    logic [15:0] r_snap_lines_p1;
    logic [15:0] r_snap_sum_p1;
    logic        r_snap_lerr_p1;

    logic        w_gap_hit;
    logic        w_start;
    logic        w_newline;
    logic        w_cont;
    logic        w_line_end;
    logic        w_frame_end;
    logic        w_emit;
    logic [15:0] w_emit_x;
    logic [15:0] w_emit_y;

    // Stage p0: input capture and blanking-gap measurement
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_de_p0  <= 1'b0;
            r_rgb_p0 <= '0;
            r_gap    <= '0;
        end else begin
            r_de_p0  <= LCD_DE;
            r_rgb_p0 <= {LCD_R, LCD_G, LCD_B};
            r_gap    <= r_de_p0 ? 16'd0 : sat_inc(r_gap);
        end
    end

    // A gap hit with DE already back high ends the old frame and starts the next in one step.
    always_comb begin
        w_gap_hit   = (r_gap >= GAP_L);
        w_frame_end = (r_state == S_HBLANK) && w_gap_hit;
        w_start     = r_de_p0 && ((r_state == S_VBLANK) ||
                      (((r_state == S_SYNC) || (r_state == S_HBLANK)) && w_gap_hit));
        w_newline   = r_de_p0 && (r_state == S_HBLANK) && !w_gap_hit;
        w_cont      = r_de_p0 && (r_state == S_ACTIVE);
        w_line_end  = !r_de_p0 && (r_state == S_ACTIVE);
        w_emit      = w_start || w_newline || w_cont;
        w_emit_x    = w_cont ? r_x : 16'd0;
        w_emit_y    = w_start ? 16'd0 : (w_newline ? sat_inc(r_y) : r_y);
    end

    // Stage p1: line/frame tracking and pixel output
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            r_state         <= S_SYNC;
            r_x             <= '0;
            r_y             <= '0;
            r_lines         <= '0;
            r_sum           <= '0;
            r_lerr          <= 1'b0;
            r_end_p1        <= 1'b0;
            r_snap_lines_p1 <= '0;
            r_snap_sum_p1   <= '0;
            r_snap_lerr_p1  <= 1'b0;
            pix_valid       <= 1'b0;
            pix_x           <= '0;
            pix_y           <= '0;
            pix_rgb         <= '0;
        end else begin
            pix_valid <= w_emit;
            r_end_p1  <= w_frame_end;
            if (w_frame_end) begin
                r_snap_lines_p1 <= r_lines;
                r_snap_sum_p1   <= r_sum;
                r_snap_lerr_p1  <= r_lerr;
            end
            if (w_emit) begin
                pix_x   <= w_emit_x;
                pix_y   <= w_emit_y;
                pix_rgb <= r_rgb_p0;
                r_x     <= sat_inc(w_emit_x);
                r_y     <= w_emit_y;
                r_sum   <= (w_start ? 16'd0 : r_sum) + r_rgb_p0;
            end
            if (w_start) begin
                r_lines <= '0;
                r_lerr  <= 1'b0;
            end
            if (w_line_end) begin
                r_lines <= sat_inc(r_lines);
                if (r_x != H_L)
                    r_lerr <= 1'b1;
            end
            case (r_state)
                S_SYNC:   if (w_gap_hit) r_state <= r_de_p0 ? S_ACTIVE : S_VBLANK;
                S_VBLANK: if (r_de_p0) r_state <= S_ACTIVE;
                S_ACTIVE: if (!r_de_p0) r_state <= S_HBLANK;
                S_HBLANK: begin
                    if (r_de_p0)
                        r_state <= S_ACTIVE;
                    else if (w_gap_hit)
                        r_state <= S_VBLANK;
                end
                default:  r_state <= S_SYNC;
            endcase
        end
    end

    // Stage p2: frame summary publication
    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            frame_done       <= 1'b0;
            frame_lines      <= '0;
            frame_checksum   <= '0;
            err_line_len     <= 1'b0;
            err_frame_height <= 1'b0;
            frame_count      <= '0;
        end else begin
            frame_done <= r_end_p1;
            if (r_end_p1) begin
                frame_lines      <= r_snap_lines_p1;
                frame_checksum   <= r_snap_sum_p1;
                err_line_len     <= r_snap_lerr_p1;
                err_frame_height <= (r_snap_lines_p1 != V_L);
                frame_count      <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_de_receiver.sv
// Bench for lcd_de_receiver: directed and randomized DE streams compared against a
// run-length reference model of the receiver's frame/line rules.
module tb_lcd_de_receiver;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int G  = 8;
    localparam int MAXN = 1024;

    logic        PixelClk = 1'b0;
    logic        RST = 1'b1;
    logic        LCD_DE = 1'b0;
    logic [4:0]  LCD_R = '0;
    logic [5:0]  LCD_G = '0;
    logic [4:0]  LCD_B = '0;
    logic        pix_valid;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [15:0] pix_rgb;
    logic        frame_done;
    logic [15:0] frame_lines;
    logic [15:0] frame_checksum;
    logic        err_line_len;
    logic        err_frame_height;
    logic [15:0] frame_count;

    lcd_de_receiver #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAME_GAP(G)) dut (
        .PixelClk(PixelClk), .RST(RST), .LCD_DE(LCD_DE),
        .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_lines(frame_lines), .frame_checksum(frame_checksum),
        .err_line_len(err_line_len), .err_frame_height(err_frame_height),
        .frame_count(frame_count)
    );

    always #5 PixelClk = ~PixelClk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_cyc  = 0;
    int obs_valid;
    int obs_done;
    int seq;

    logic        s_de[$];
    logic [15:0] s_rgb[$];

    logic        e_v[MAXN];
    logic [15:0] e_x[MAXN];
    logic [15:0] e_y[MAXN];
    logic [15:0] e_rgb[MAXN];
    logic        e_d[MAXN];
    logic [15:0] e_lines[MAXN];
    logic [15:0] e_sum[MAXN];
    logic        e_lerr[MAXN];
    logic        e_herr[MAXN];
    logic [15:0] e_cnt[MAXN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s @%0d: observed %0h expected %0h", tag, cur_cyc, obs, exp);
        end
    endtask

    task automatic push_low(input int n);
        for (int i = 0; i < n; i++) begin
            s_de.push_back(1'b0);
            s_rgb.push_back(16'($urandom));
        end
    endtask

    // mode 0: random colours, 1: incrementing sequence, 2: all ones
    task automatic push_line(input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            s_de.push_back(1'b1);
            if (mode == 1) begin
                s_rgb.push_back(16'(seq));
                seq++;
            end else if (mode == 2) begin
                s_rgb.push_back(16'hFFFF);
            end else begin
                s_rgb.push_back(16'($urandom));
            end
        end
    endtask

    task automatic push_frame(input int mode);
        for (int l = 0; l < V; l++) begin
            push_line(H, mode);
            if (l < V - 1) push_low(3);
        end
    endtask

    // Walk the input as runs: a low run of G cycles closes the frame and arms the receiver;
    // pixels appear 2 cycles after their input cycle, frame summaries 4 cycles after the G-th low.
    task automatic build_model(input int n);
        int lowrun, x, y, lines, cnt;
        bit synced, in_frame, line_open, lerr;
        logic [15:0] sum, h_lines, h_sum;
        bit h_lerr, h_herr;
        lowrun = 0; x = 0; y = 0; lines = 0; cnt = 0; sum = '0;
        synced = 0; in_frame = 0; line_open = 0; lerr = 0;
        for (int t = 0; t < MAXN; t++) begin
            e_v[t] = 0; e_x[t] = '0; e_y[t] = '0; e_rgb[t] = '0; e_d[t] = 0;
            e_lines[t] = '0; e_sum[t] = '0; e_lerr[t] = 0; e_herr[t] = 0; e_cnt[t] = '0;
        end
        for (int t = 0; t < n; t++) begin
            if (s_de[t]) begin
                lowrun = 0;
                if (synced) begin
                    if (!in_frame) begin
                        in_frame = 1; x = 0; y = 0; lines = 0; sum = '0; lerr = 0;
                    end else if (!line_open) begin
                        y++; x = 0;
                    end
                    line_open = 1;
                    if (t + 2 < MAXN) begin
                        e_v[t+2] = 1; e_x[t+2] = 16'(x); e_y[t+2] = 16'(y); e_rgb[t+2] = s_rgb[t];
                    end
                    x++;
                    sum = sum + s_rgb[t];
                end
            end else begin
                if (line_open) begin
                    line_open = 0;
                    lines++;
                    if (x != H) lerr = 1;
                end
                lowrun++;
                if (lowrun == G) begin
                    if (in_frame && t + 4 < MAXN) begin
                        e_d[t+4] = 1; e_lines[t+4] = 16'(lines); e_sum[t+4] = sum;
                        e_lerr[t+4] = lerr; e_herr[t+4] = (lines != V);
                    end
                    in_frame = 0;
                    synced = 1;
                end
            end
        end
        h_lines = '0; h_sum = '0; h_lerr = 0; h_herr = 0;
        for (int t = 0; t < MAXN; t++) begin
            if (e_d[t]) begin
                h_lines = e_lines[t]; h_sum = e_sum[t]; h_lerr = e_lerr[t]; h_herr = e_herr[t];
                cnt++;
            end
            e_lines[t] = h_lines; e_sum[t] = h_sum; e_lerr[t] = h_lerr; e_herr[t] = h_herr;
            e_cnt[t] = 16'(cnt);
        end
    endtask

    task automatic run_phase();
        int n;
        logic [15:0] rgb;
        n = s_de.size();
        build_model(n);
        obs_valid = 0;
        obs_done  = 0;
        RST = 1'b1;
        LCD_DE = 1'b0;
        repeat (2) @(posedge PixelClk);
        for (int m = 0; m < n; m++) begin
            @(posedge PixelClk);
            #1;
            if (m == 0) RST = 1'b0;
            rgb = s_rgb[m];
            LCD_DE = s_de[m];
            LCD_R = rgb[15:11];
            LCD_G = rgb[10:5];
            LCD_B = rgb[4:0];
            @(negedge PixelClk);
            cur_cyc = m;
            if (pix_valid === 1'b1) obs_valid++;
            if (frame_done === 1'b1) obs_done++;
            chk("pix_valid", 32'(pix_valid), 32'(e_v[m]));
            if (e_v[m]) begin
                chk("pix_x", 32'(pix_x), 32'(e_x[m]));
                chk("pix_y", 32'(pix_y), 32'(e_y[m]));
                chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb[m]));
            end
            chk("frame_done", 32'(frame_done), 32'(e_d[m]));
            chk("frame_lines", 32'(frame_lines), 32'(e_lines[m]));
            chk("frame_checksum", 32'(frame_checksum), 32'(e_sum[m]));
            chk("err_line_len", 32'(err_line_len), 32'(e_lerr[m]));
            chk("err_frame_height", 32'(err_frame_height), 32'(e_herr[m]));
            chk("frame_count", 32'(frame_count), 32'(e_cnt[m]));
        end
        s_de.delete();
        s_rgb.delete();
    endtask

    initial begin
        // Clean frame with RGB 1..12
        seq = 1;
        push_low(10);
        push_frame(1);
        push_low(12);
        run_phase();
        chk("clean_valid_count", 32'(obs_valid), 32'd12);
        chk("clean_done_count", 32'(obs_done), 32'd1);
        chk("clean_lines", 32'(frame_lines), 32'd3);
        chk("clean_checksum", 32'(frame_checksum), 32'h004E);
        chk("clean_err_len", 32'(err_line_len), 32'd0);
        chk("clean_err_height", 32'(err_frame_height), 32'd0);
        chk("clean_count", 32'(frame_count), 32'd1);

        // Stream begins mid-frame with no preceding gap
        push_line(4, 0); push_low(3); push_line(4, 0); push_low(3); push_line(2, 0);
        push_low(8);
        push_frame(0);
        push_low(12);
        run_phase();
        chk("nogap_valid_count", 32'(obs_valid), 32'd12);
        chk("nogap_count", 32'(frame_count), 32'd1);

        // Short second line, then a clean frame
        push_low(10);
        push_line(4, 0); push_low(3); push_line(3, 0); push_low(3); push_line(4, 0);
        push_low(12);
        push_frame(0);
        push_low(12);
        run_phase();
        chk("short_done_count", 32'(obs_done), 32'd2);
        chk("short_cleared_err", 32'(err_line_len), 32'd0);
        chk("short_count", 32'(frame_count), 32'd2);

        // Inter-line gaps of G-1 (same frame) and G (frame split)
        push_low(10);
        push_line(4, 0); push_low(7); push_line(4, 0); push_low(3); push_line(4, 0);
        push_low(12);
        push_line(4, 0); push_low(8); push_line(4, 0); push_low(3); push_line(4, 0);
        push_low(12);
        run_phase();
        chk("gap_done_count", 32'(obs_done), 32'd3);
        chk("gap_lines", 32'(frame_lines), 32'd2);
        chk("gap_err_height", 32'(err_frame_height), 32'd1);

        // Checksum wrap
        push_low(10);
        push_frame(2);
        push_low(12);
        run_phase();
        chk("wrap_checksum", 32'(frame_checksum), 32'hFFF4);
        chk("wrap_lines", 32'(frame_lines), 32'd3);

        // Random geometry, ending mid-line, then asynchronous reset
        push_low(10);
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = int'($urandom_range(1, 4));
            for (int l = 0; l < nl; l++) begin
                push_line(int'($urandom_range(1, 6)), 0);
                if (l < nl - 1) push_low(int'($urandom_range(1, 7)));
            end
            push_low(int'($urandom_range(8, 14)));
        end
        push_line(4, 0); push_low(2); push_line(2, 0);
        run_phase();
        @(posedge PixelClk);
        #2;
        RST = 1'b1;
        #1;
        cur_cyc = -1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_x", 32'(pix_x), 32'd0);
        chk("rst_pix_y", 32'(pix_y), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_frame_lines", 32'(frame_lines), 32'd0);
        chk("rst_frame_checksum", 32'(frame_checksum), 32'd0);
        chk("rst_err_len", 32'(err_line_len), 32'd0);
        chk("rst_err_height", 32'(err_frame_height), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);

        // Re-sync after reset needs a full gap before the first frame
        push_line(3, 0); push_low(3);
        push_low(10);
        push_frame(0);
        push_low(12);
        run_phase();
        chk("resync_count", 32'(frame_count), 32'd1);
        chk("resync_done_count", 32'(obs_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
